// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin, time-sliced sharing of the six digits and LED bank
// among NREQ requesters, with the owner's image registered onto the pins.
module disp_arbiter #(
    parameter int         NREQ      = 3,
    parameter int         SLICE_CYC = 25000000,
    parameter logic [7:0] IDLE_HEX  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*48-1:0] src_hex,
    input  logic [NREQ*16-1:0] src_led,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        owner,
    output logic              busy,
    output logic              preempt,
    output logic [7:0]        sthex0,
    output logic [7:0]        sthex1,
    output logic [7:0]        sthex2,
    output logic [7:0]        sthex3,
    output logic [7:0]        sthex4,
    output logic [7:0]        sthex5,
    output logic [15:0]       stled
);
    localparam int CW = $clog2(SLICE_CYC);
    localparam logic [CW-1:0] RELOAD = CW'(SLICE_CYC - 1);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      owner_q, owner_d, rr_q, rr_d;
    logic            busy_q, busy_d, preempt_q, preempt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [47:0]     hex_q, hex_d;
    logic [15:0]     led_q, led_d;
    logic [7:0]      req8;
    logic [47:0]     hex_a [8];
    logic [15:0]     led_a [8];
    logic [2:0]      first_sel, other_sel, next_rr;
    logic            first_ok, other_ok, rel, expd;
    assign req8 = 8'(req);
    for (genvar g = 0; g < 8; g++) begin : g_src
        if (g < NREQ) begin : g_on
            assign hex_a[g] = src_hex[48*g +: 48];
            assign led_a[g] = src_led[16*g +: 16];
        end else begin : g_off
            assign hex_a[g] = '0;
            assign led_a[g] = '0;
        end
    end
    // first_sel scans every index from rr; other_sel scans after the owner, skipping it
    always_comb begin
        first_ok  = 1'b0;
        first_sel = 3'd0;
        other_ok  = 1'b0;
        other_sel = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!first_ok && req8[3'((int'(rr_q) + k) % NREQ)]) begin
                first_ok  = 1'b1;
                first_sel = 3'((int'(rr_q) + k) % NREQ);
            end
        end
        for (int k = 1; k < NREQ; k++) begin
            if (!other_ok && req8[3'((int'(owner_q) + k) % NREQ)]) begin
                other_ok  = 1'b1;
                other_sel = 3'((int'(owner_q) + k) % NREQ);
            end
        end
        next_rr = 3'((int'(owner_q) + 1) % NREQ);
        rel     = !req8[owner_q];
        expd    = cnt_q == '0;
    end
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;
        hex_d     = {6{IDLE_HEX}};
        led_d     = '0;
        if (state_q == IDLE) begin
            if (first_ok) begin
                state_d = OWNED;
                gnt_d   = NREQ'(1) << first_sel;
                owner_d = first_sel;
                busy_d  = 1'b1;
                cnt_d   = RELOAD;
            end
        end else begin
            hex_d = hex_a[owner_q];
            led_d = led_a[owner_q];
            cnt_d = expd ? cnt_q : cnt_q - CW'(1);
            if (rel || expd) begin
                if (other_ok) begin
                    gnt_d     = NREQ'(1) << other_sel;
                    owner_d   = other_sel;
                    cnt_d     = RELOAD;
                    rr_d      = next_rr;
                    preempt_d = !rel;
                end else if (rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    rr_d    = next_rr;
                    hex_d   = {6{IDLE_HEX}};
                    led_d   = '0;
                end else begin
                    cnt_d = RELOAD;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= 3'd0;
            rr_q      <= 3'd0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
            hex_q     <= {6{IDLE_HEX}};
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
            hex_q     <= hex_d;
            led_q     <= led_d;
        end
    end
    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;
    assign sthex0  = hex_q[7:0];
    assign sthex1  = hex_q[15:8];
    assign sthex2  = hex_q[23:16];
    assign sthex3  = hex_q[31:24];
    assign sthex4  = hex_q[39:32];
    assign sthex5  = hex_q[47:40];
    assign stled   = led_q;
endmodule
